change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream consumer of the vending controller's vend strobe and 3-bit change code. The change code is in units of 5c: 0 = none, 1 = 5c, 2 = 10c, 3 = 15c, 4 = 20c.
- Converts each change amount into a sequence of single-coin eject requests to the coin hopper, using a request/acknowledge handshake.
- Dimes are used first; nickels are used for the remainder or when the dime tube is empty.
- A one-entry pending buffer absorbs a vend that arrives while a payout is still in progress.

Parameters:
- GAP_CYCLES, 4: idle cycles in GAP after each acknowledged coin, before the next selection (range 1..255).
- ACK_TIMEOUT, 255: maximum cycles o_req may stay high without i_ack before the payout is abandoned (range 2..255).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_soda  in  1  vend strobe, single-cycle; qualifies i_change
- i_change  in  3  change code in 5c units; sampled only when i_soda=1
- i_dime_empty  in  1  dime tube empty; level signal
- i_ack  in  1  hopper has ejected the requested coin
- o_req  out  1  eject request; held until ack or timeout
- o_coin_sel  out  1  0 = nickel, 1 = dime; stable while o_req=1
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when a payout completes
- o_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE; remaining, pending, gap and timeout counters clear.
  - o_req, o_coin_sel, o_busy, o_done, o_err all 0; o_req drops immediately.
  - Reset mid-payout abandons it with no o_done.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- remaining is a 3-bit register holding the unpaid amount in 5c units.
- States: IDLE, SELECT, REQ, GAP, DONE.
- IDLE:
  - i_soda=1 and i_change in 1..4: load remaining, go to SELECT.
  - i_soda=1 and i_change=0: go to DONE (o_done pulses next cycle; no coins).
  - i_soda=1 and i_change in 5..7: set o_err, stay in IDLE, nothing loaded.
- SELECT (exactly 1 cycle):
  - remaining=0: go to DONE.
  - remaining>=2 and i_dime_empty=0: o_coin_sel<=1, go to REQ.
  - Otherwise: o_coin_sel<=0, go to REQ.
  - i_dime_empty is sampled only here.
- REQ:
  - o_req=1. Timeout counter starts at 1 in the first REQ cycle and increments each cycle.
  - i_ack=1: remaining -= 2 (dime) or 1 (nickel); gap counter <= GAP_CYCLES; go to GAP. o_req is low in the next cycle.
  - Counter = ACK_TIMEOUT with i_ack=0: set o_err, clear remaining, go to DONE.
  - i_ack while not in REQ is ignored.
- GAP: decrement the gap counter each cycle; go to SELECT in the cycle after it reaches 1. GAP lasts exactly GAP_CYCLES cycles.
- DONE (1 cycle):
  - o_done=1.
  - If pending is valid: move it into remaining, clear pending, go to SELECT (o_busy stays high).
  - Otherwise: go to IDLE.
- Latency: i_soda in cycle 0 gives SELECT in cycle 1 and o_req in cycle 2.
- Pending buffer:
  - i_soda=1 in any state other than IDLE with a valid code 0..4: captured into pending if pending is empty.
  - If pending is already full: set o_err and drop the new code.
  - An invalid code while busy sets o_err and is never stored.
  - i_soda in the DONE cycle is captured into pending before the DONE-to-pending transfer is evaluated, so it is served immediately.
  - A pending code of 0 produces SELECT then DONE (o_done pulse, no coins).
- Dime-empty rule: remaining=4 with i_dime_empty=1 throughout gives 4 nickels.
- o_coin_sel holds its last value outside REQ.

Test Plan:
- Reset, i_soda=1 with i_change=3, i_ack=1 during every REQ, GAP_CYCLES=4 -> dime req cycle 2, nickel req cycle 8, o_done=1 cycle 14, IDLE cycle 15, o_err=0.
- i_change=4, i_dime_empty=1 -> four nickel requests (o_coin_sel=0); i_dime_empty rising after the first dime of a 4 -> dime then two nickels.
- i_change=2, i_ack held low -> o_req high for exactly 255 cycles, then o_err=1, o_done pulse, no coins counted, and o_req stays low in IDLE.
- During payout of 4, vend i_change=1 then i_change=2 -> first stored, second sets o_err and is dropped; after o_done, one nickel is dispensed with o_busy never dropping between payouts.
- i_soda with i_change=0 -> o_done in the next cycle, no o_req; i_soda with i_change=6 in IDLE -> o_err=1, state stays IDLE.
- Assert i_rst_n=0 while o_req=1 -> o_req drops without waiting for a clock edge, all outputs reset to 0, and no o_done.

Source files
------------

// File: rtl/change_dispenser.sv
// Turns a vend's change code (5c units) into single-coin hopper ejects, dimes first.
// Latency: vend in cycle 0 -> SELECT in cycle 1 -> first o_req in cycle 2.
// Backpressure: o_req held until i_ack or timeout; one vend buffered while busy, extras flag o_err.
module change_dispenser #(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_soda,
    input  logic [2:0] i_change,
    input  logic       i_dime_empty,
    input  logic       i_ack,
    output logic       o_req,
    output logic       o_coin_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);
    localparam logic [7:0] TO_MAX   = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] remaining, remaining_nxt;
    logic [2:0] pend_dat, pend_dat_nxt;
    logic       pend_vld, pend_vld_nxt;
    logic [7:0] gap_cnt, gap_cnt_nxt;
    logic [7:0] to_cnt, to_cnt_nxt;
    logic       coin_sel, coin_sel_nxt;
    logic       err, err_nxt;
    logic       code_bad;

    assign code_bad = (i_change > 3'd4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            pend_dat  <= '0;
            pend_vld  <= 1'b0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            coin_sel  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            pend_dat  <= pend_dat_nxt;
            pend_vld  <= pend_vld_nxt;
            gap_cnt   <= gap_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            coin_sel  <= coin_sel_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pend_dat_nxt  = pend_dat;
        pend_vld_nxt  = pend_vld;
        gap_cnt_nxt   = gap_cnt;
        to_cnt_nxt    = to_cnt;
        coin_sel_nxt  = coin_sel;
        err_nxt       = err;

        // Capture happens before the DONE transfer below so a vend in DONE is served at once.
        if (state != S_IDLE && i_soda) begin
            if (code_bad || pend_vld) begin
                err_nxt = 1'b1;
            end else begin
                pend_vld_nxt = 1'b1;
                pend_dat_nxt = i_change;
            end
        end

        case (state)
            S_IDLE: begin
                if (i_soda) begin
                    if (code_bad) begin
                        err_nxt = 1'b1;
                    end else if (i_change == 3'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        remaining_nxt = i_change;
                        state_nxt     = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (remaining == 3'd0) begin
                    state_nxt = S_DONE;
                end else begin
                    coin_sel_nxt = (remaining >= 3'd2) && !i_dime_empty;
                    to_cnt_nxt   = 8'd1;
                    state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    remaining_nxt = remaining - (coin_sel ? 3'd2 : 3'd1);
                    gap_cnt_nxt   = GAP_INIT;
                    state_nxt     = S_GAP;
                end else if (to_cnt == TO_MAX) begin
                    err_nxt       = 1'b1;
                    remaining_nxt = '0;
                    state_nxt     = S_DONE;
                end else begin
                    to_cnt_nxt = to_cnt + 8'd1;
                end
            end
            S_GAP: begin
                gap_cnt_nxt = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_nxt = S_SELECT;
                end
            end
            S_DONE: begin
                if (pend_vld_nxt) begin
                    remaining_nxt = pend_dat_nxt;
                    pend_vld_nxt  = 1'b0;
                    state_nxt     = S_SELECT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_req      = (state == S_REQ);
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_coin_sel = coin_sel;
    assign o_err      = err;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized payouts vs a coin model.
module tb_change_dispenser;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_soda = 1'b0;
    logic [2:0] i_change = 3'd0;
    logic       i_dime_empty = 1'b0;
    logic       i_ack = 1'b0;
    logic       o_req, o_coin_sel, o_busy, o_done, o_err;

    int tests_run = 0;
    int tests_failed = 0;

    change_dispenser #(.GAP_CYCLES(4), .ACK_TIMEOUT(255)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soda(i_soda), .i_change(i_change),
        .i_dime_empty(i_dime_empty), .i_ack(i_ack), .o_req(o_req), .o_coin_sel(o_coin_sel),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_soda = 0; i_change = 0; i_ack = 0; i_dime_empty = 0;
        i_rst_n = 0;
        tick(); tick();
        i_rst_n = 1;
        tick();
    endtask

    // Reference: coins paid for a code, dimes first while the tube has dimes.
    function automatic void model_coins(input int code, input bit dime_e, input int flip_after,
                                        output int n, output logic [3:0] bits);
        int  rem = code;
        bit  de  = dime_e;
        n = 0; bits = '0;
        while (rem > 0) begin
            bit dime = (rem >= 2) && !de;
            bits[n] = dime;
            rem -= dime ? 2 : 1;
            n++;
            if (flip_after >= 0 && n > flip_after) de = 1;
        end
    endfunction

    // Vends one code and serves each request after ack_dly cycles; returns coins seen.
    task automatic drive_payout(input logic [2:0] code, input bit dime_e, input int flip_after,
                                input int ack_dly, output int nco, output logic [3:0] bits,
                                output bit done_ok);
        nco = 0; bits = '0; done_ok = 0;
        i_ack = 0; i_dime_empty = dime_e; i_soda = 1; i_change = code;
        tick();
        i_soda = 0;
        for (int c = 0; c < 400; c++) begin
            if (o_done) begin
                done_ok = 1;
                break;
            end
            if (o_req) begin
                if (nco < 4) bits[nco] = o_coin_sel;
                nco++;
                if (flip_after >= 0 && nco > flip_after) i_dime_empty = 1;
                repeat (ack_dly) tick();
                i_ack = 1;
                tick();
                i_ack = 0;
            end else begin
                tick();
            end
        end
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({o_req, o_coin_sel, o_busy, o_done, o_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b want=00000", {o_req, o_coin_sel, o_busy, o_done, o_err});
        end
    endtask

    task automatic test_basic_timing();
        int req_cyc[$];
        int sel_seen[$];
        int done_cyc = -1;
        logic busy15 = 1'bx;
        apply_reset();
        i_ack = 1;
        i_soda = 1; i_change = 3;
        tick();
        i_soda = 0;
        for (int c = 1; c <= 16; c++) begin
            if (o_req) begin req_cyc.push_back(c); sel_seen.push_back(int'(o_coin_sel)); end
            if (o_done && done_cyc < 0) done_cyc = c;
            if (c == 15) busy15 = o_busy;
            tick();
        end
        i_ack = 0;
        tests_run++;
        if (req_cyc.size() !== 2 || req_cyc[0] !== 2 || req_cyc[1] !== 8) begin
            tests_failed++;
            $display("FAIL basic_req_cycles got_n=%0d first=%0d want 2 reqs at 2,8",
                     req_cyc.size(), (req_cyc.size() > 0) ? req_cyc[0] : -1);
        end
        tests_run++;
        if (sel_seen.size() !== 2 || sel_seen[0] !== 1 || sel_seen[1] !== 0) begin
            tests_failed++;
            $display("FAIL basic_coin_order got_n=%0d want dime,nickel", sel_seen.size());
        end
        tests_run++;
        if (done_cyc !== 14) begin
            tests_failed++;
            $display("FAIL basic_done_cycle got=%0d want=14", done_cyc);
        end
        tests_run++;
        if (busy15 !== 1'b0 || o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle_noerr busy15=%b err=%b want 0,0", busy15, o_err);
        end
    endtask

    task automatic test_dime_empty();
        int n, en; logic [3:0] b, eb; bit ok;
        apply_reset();
        drive_payout(3'd4, 1'b1, -1, 0, n, b, ok);
        model_coins(4, 1'b1, -1, en, eb);
        tests_run++;
        if (!ok || n !== en || b !== eb) begin
            tests_failed++;
            $display("FAIL dime_empty_4 got n=%0d bits=%b done=%0d want n=%0d bits=%b", n, b, ok, en, eb);
        end
        apply_reset();
        drive_payout(3'd4, 1'b0, 1, 0, n, b, ok);
        model_coins(4, 1'b0, 1, en, eb);
        tests_run++;
        if (!ok || n !== en || b !== eb) begin
            tests_failed++;
            $display("FAIL dime_empty_rise got n=%0d bits=%b done=%0d want n=%0d bits=%b", n, b, ok, en, eb);
        end
        i_dime_empty = 0;
    endtask

    task automatic test_timeout();
        int req_cycles = 0, dones = 0;
        logic err_at_done = 1'b0;
        apply_reset();
        i_soda = 1; i_change = 2;
        tick();
        i_soda = 0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            if (o_req) req_cycles++;
            if (o_done) begin dones++; err_at_done = o_err; end
            tick();
        end
        tests_run++;
        if (req_cycles !== 255) begin
            tests_failed++;
            $display("FAIL timeout_req_len got=%0d want=255", req_cycles);
        end
        tests_run++;
        if (dones !== 1 || err_at_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_done_err dones=%0d err=%b want 1,1", dones, err_at_done);
        end
        tick(); tick();
        tests_run++;
        if (o_req !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_idle req=%b busy=%b err=%b want 0,0,1", o_req, o_busy, o_err);
        end
    endtask

    task automatic test_pending();
        int dones = 0, coins = 0;
        logic [3:0] bits = '0;
        bit busy_drop = 0;
        apply_reset();
        i_ack = 1;
        i_soda = 1; i_change = 4;
        tick();
        for (int c = 1; c < 80; c++) begin
            if (o_req) begin if (coins < 4) bits[coins] = o_coin_sel; coins++; end
            if (o_done) dones++;
            if (dones == 2) break;
            if (!o_busy) busy_drop = 1;
            i_soda = (c == 3) || (c == 5);
            i_change = (c == 3) ? 3'd1 : 3'd2;
            tick();
        end
        i_soda = 0; i_ack = 0;
        tests_run++;
        if (coins !== 3 || bits[2:0] !== 3'b011) begin
            tests_failed++;
            $display("FAIL pending_coins got n=%0d bits=%b want n=3 bits=011", coins, bits[2:0]);
        end
        tests_run++;
        if (dones !== 2 || busy_drop !== 0) begin
            tests_failed++;
            $display("FAIL pending_done_busy dones=%0d busy_drop=%0d want 2,0", dones, busy_drop);
        end
        tests_run++;
        if (o_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending_overflow_err got=%b want=1", o_err);
        end
        tick();
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL pending_final_idle busy=%b want=0", o_busy);
        end
    endtask

    task automatic test_zero_invalid();
        apply_reset();
        i_soda = 1; i_change = 0;
        tick();
        i_soda = 0;
        tests_run++;
        if (o_done !== 1'b1 || o_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done done=%b req=%b want 1,0", o_done, o_req);
        end
        tick();
        tests_run++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_after done=%b busy=%b err=%b want 0,0,0", o_done, o_busy, o_err);
        end
        i_soda = 1; i_change = 6;
        tick();
        i_soda = 0;
        tick();
        tests_run++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_req !== 1'b0 || o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_idle err=%b busy=%b req=%b done=%b want 1,0,0,0", o_err, o_busy, o_req, o_done);
        end
    endtask

    task automatic test_async_reset();
        bit saw_req = 0, saw_done = 0;
        apply_reset();
        i_soda = 1; i_change = 4;
        tick();
        i_soda = 0;
        for (int c = 0; c < 10 && !saw_req; c++) begin
            if (o_req) saw_req = 1; else tick();
        end
        tests_run++;
        if (!saw_req) begin
            tests_failed++;
            $display("FAIL async_setup req never seen want=1");
        end
        #3 i_rst_n = 0;
        #1;
        tests_run++;
        if ({o_req, o_coin_sel, o_busy, o_done, o_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset_outputs got=%b want=00000", {o_req, o_coin_sel, o_busy, o_done, o_err});
        end
        tick(); tick();
        i_rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            if (o_done || o_busy) saw_done = 1;
            tick();
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL async_no_done saw done/busy after reset got=1 want=0");
        end
    endtask

    task automatic test_random();
        int n, en; logic [3:0] b, eb; bit ok;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            int  code = $urandom_range(0, 4);
            bit  de   = 1'($urandom_range(0, 1));
            int  dly  = $urandom_range(0, 6);
            drive_payout(3'(code), de, -1, dly, n, b, ok);
            model_coins(code, de, -1, en, eb);
            tests_run++;
            if (!ok || n !== en || b !== eb) begin
                tests_failed++;
                $display("FAIL random_payout[%0d] code=%0d de=%0d got n=%0d bits=%b done=%0d want n=%0d bits=%b",
                         k, code, de, n, b, ok, en, eb);
            end
        end
        tests_run++;
        if (o_err !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_end err=%b busy=%b want 0,0", o_err, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_dime_empty();
        test_timeout();
        test_pending();
        test_zero_invalid();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
